// File: rtl/quota_rr_arbiter.sv
// Credit-limited round-robin drain of WIDTH FWFT source FIFOs into one output FIFO.
// Each owner keeps the output for up to QUOTA words; HOLD_REQ keeps a record from being split.

module quota_rr_lane #(
  parameter int QUOTA_W = 4
) (
  input  logic [QUOTA_W-1:0] quota,
  output logic [QUOTA_W-1:0] q_eff
);
  // A zero quota would stall rotation; treat it as a single word.
  assign q_eff = (quota == '0) ? QUOTA_W'(1) : quota;
endmodule

module quota_rr_arbiter #(
  parameter int WIDTH   = 11,
  parameter int DATA_W  = 32,
  parameter int QUOTA_W = 4,
  parameter int IDX_W   = 4
) (
  input  logic                      BUS_CLK,
  input  logic                      BUS_RST,
  input  logic [WIDTH-1:0]          WRITE_REQ,
  input  logic [WIDTH-1:0]          HOLD_REQ,
  input  logic [WIDTH*DATA_W-1:0]   DATA_IN,
  input  logic [WIDTH*QUOTA_W-1:0]  QUOTA,
  input  logic                      READY_OUT,
  output logic [WIDTH-1:0]          READ_GRANT,
  output logic                      WRITE_OUT,
  output logic [DATA_W-1:0]         DATA_OUT,
  output logic [IDX_W-1:0]          GRANT_ID,
  output logic                      BUSY
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                          state;
  logic [IDX_W-1:0]                ptr;
  logic [QUOTA_W-1:0]              cnt, cnt_nxt;
  logic [WIDTH-1:0][DATA_W-1:0]    din;
  logic [WIDTH-1:0][QUOTA_W-1:0]   quota, q_eff;
  logic [IDX_W-1:0]                pick;
  logic                            own_req, own_hold, xfer, burst_end;

  assign din   = DATA_IN;
  assign quota = QUOTA;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    quota_rr_lane #(.QUOTA_W(QUOTA_W)) u_lane (
      .quota (quota[i]),
      .q_eff (q_eff[i])
    );
  end

  // First requester at or after the pointer, wrapping past WIDTH-1.
  always_comb begin
    logic found;
    int   s;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < WIDTH; k++) begin
      s = int'(ptr) + k;
      if (s >= WIDTH) s = s - WIDTH;
      if (!found && WRITE_REQ[s]) begin
        found = 1'b1;
        pick  = IDX_W'(s);
      end
    end
  end

  assign own_req   = WRITE_REQ[GRANT_ID];
  assign own_hold  = HOLD_REQ[GRANT_ID];
  assign WRITE_OUT = (state == BURST) && own_req && !BUS_RST;
  assign xfer      = WRITE_OUT && READY_OUT;
  assign DATA_OUT  = din[GRANT_ID];

  always_comb begin
    READ_GRANT = '0;
    for (int i = 0; i < WIDTH; i++)
      if (xfer && (GRANT_ID == IDX_W'(i))) READ_GRANT[i] = 1'b1;
  end

  // Count saturates so a long held record cannot wrap back under the quota.
  assign cnt_nxt   = (xfer && (cnt != '1)) ? cnt + 1'b1 : cnt;
  assign burst_end = !own_hold && ((cnt_nxt >= q_eff[GRANT_ID]) || !own_req);

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state    <= IDLE;
      ptr      <= '0;
      GRANT_ID <= '0;
      BUSY     <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|WRITE_REQ) begin
            GRANT_ID <= pick;
            cnt      <= '0;
            BUSY     <= 1'b1;
            state    <= BURST;
          end
        end
        BURST: begin
          cnt <= cnt_nxt;
          if (burst_end) begin
            ptr   <= (GRANT_ID == IDX_W'(WIDTH-1)) ? '0 : GRANT_ID + 1'b1;
            BUSY  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quota_rr_arbiter.sv
// Directed bench for quota_rr_arbiter: FWFT source model, per-cycle grant log, hand-computed expectations.

module tb_quota_rr_arbiter;
  localparam int W = 11, DW = 32, QW = 4, IW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [W-1:0]      wreq, hreq, gnt;
  logic [W*DW-1:0]   din;
  logic [W*QW-1:0]   quota;
  logic              rdy, wout, busy;
  logic [DW-1:0]     dout;
  logic [IW-1:0]     gid;

  always #5 clk = ~clk;

  quota_rr_arbiter #(.WIDTH(W), .DATA_W(DW), .QUOTA_W(QW), .IDX_W(IW)) dut (
    .BUS_CLK    (clk),
    .BUS_RST    (rst),
    .WRITE_REQ  (wreq),
    .HOLD_REQ   (hreq),
    .DATA_IN    (din),
    .QUOTA      (quota),
    .READY_OUT  (rdy),
    .READ_GRANT (gnt),
    .WRITE_OUT  (wout),
    .DATA_OUT   (dout),
    .GRANT_ID   (gid),
    .BUSY       (busy)
  );

  logic [DW-1:0] mem [W][16];
  int            rd [W];
  int            wrp [W];
  int            nchk = 0, nerr = 0, cyc = 0;
  bit            hold5_en;
  logic [W-1:0]  gnt_log[$];
  logic [DW-1:0] d_log[$];
  logic [DW-1:0] xdat[$];
  int            xid[$], xcyc[$], xgid[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int src, input int k);
    return DW'((src << 24) | k);
  endfunction

  task automatic push(input int src, input int n);
    for (int k = 0; k < n; k++) begin
      mem[src][wrp[src]] = word(src, wrp[src]);
      wrp[src]++;
    end
  endtask

  task automatic set_q(input int src, input int q);
    quota[src*QW +: QW] = QW'(q);
  endtask

  task automatic drive();
    hreq = '0;
    for (int i = 0; i < W; i++) begin
      wreq[i] = (rd[i] != wrp[i]);
      din[i*DW +: DW] = wreq[i] ? mem[i][rd[i]] : '0;
    end
    if (hold5_en && rd[5] < 6) hreq[5] = 1'b1;
  endtask

  // One cycle: drive after negedge, sample comb outputs, pop on posedge.
  task automatic step();
    logic [W-1:0] gl;
    drive();
    #1;
    gl = gnt;
    gnt_log.push_back(gl);
    d_log.push_back(dout);
    for (int i = 0; i < W; i++)
      if (gl[i]) begin
        xid.push_back(i); xdat.push_back(dout); xcyc.push_back(cyc); xgid.push_back(int'(gid));
      end
    @(posedge clk);
    for (int i = 0; i < W; i++) if (gl[i]) rd[i]++;
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic start(input string tag);
    for (int i = 0; i < W; i++) begin rd[i] = 0; wrp[i] = 0; end
    hold5_en = 1'b0;
    rdy = 1'b1;
    for (int i = 0; i < W; i++) set_q(i, 1);
    rst = 1'b1;
    step();
    chk({tag, "_rst_gnt"}, gnt_log[gnt_log.size()-1], '0);
    chk({tag, "_rst_busy"}, busy, 1'b0);
    chk({tag, "_rst_gid"}, gid, '0);
    rst = 1'b0;
    gnt_log.delete(); d_log.delete(); xdat.delete(); xid.delete(); xcyc.delete(); xgid.delete();
    cyc = 0;
  endtask

  function automatic int qi(input int k);
    return (k < xid.size()) ? xid[k] : -1;
  endfunction

  initial begin
    logic [8:0] p9;
    logic [5:0] p6, rs;
    logic [3:0] p4;
    wreq = '0; hreq = '0; din = '0; quota = '0; rdy = 1'b0; rst = 1'b1;
    @(negedge clk);

    // 1: source 3, quota 2, five words -> 2,idle,2,idle,1
    start("t1");
    set_q(3, 2); push(3, 5);
    run(10);
    for (int c = 0; c < 9; c++) p9[c] = gnt_log[c][3];
    chk("t1_pat", p9, 9'b010110110);
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_nwords", xid.size(), 5);
    for (int k = 0; k < 5; k++) chk("t1_data", (k < xdat.size()) ? xdat[k] : '1, word(3, k));

    // 2: all sources, quota 1 -> strict rotation 0..10,0
    start("t2");
    for (int i = 0; i < W; i++) push(i, 2);
    run(30);
    for (int k = 0; k < 12; k++) begin
      chk("t2_order", qi(k), k % W);
      chk("t2_gid", (k < xgid.size()) ? xgid[k] : -1, k % W);
    end

    // 3: source 5 holds past quota 4 for six words, then source 6
    start("t3");
    set_q(5, 4); push(5, 6); push(6, 1);
    hold5_en = 1'b1;
    run(12);
    chk("t3_nwords", xid.size(), 7);
    chk("t3_src5_last", qi(5), 5);
    chk("t3_cyc6", (xcyc.size() > 5) ? xcyc[5] : -1, 6);
    chk("t3_next", qi(6), 6);
    chk("t3_next_cyc", (xcyc.size() > 6) ? xcyc[6] : -1, 9);

    // 4: source 0 under backpressure 1,0,0,1
    start("t4");
    set_q(0, 4); push(0, 2);
    rs = 6'b110011;
    for (int c = 0; c < 6; c++) begin rdy = rs[c]; step(); end
    rdy = 1'b1;
    for (int c = 1; c < 5; c++) p4[c-1] = gnt_log[c][0];
    chk("t4_gnt", p4, 4'b1001);
    chk("t4_stall_d2", d_log[2], word(0, 1));
    chk("t4_stall_d3", d_log[3], word(0, 1));
    chk("t4_x0", (xdat.size() > 0) ? xdat[0] : '1, word(0, 0));
    chk("t4_x1", (xdat.size() > 1) ? xdat[1] : '1, word(0, 1));
    chk("t4_busy_end", busy, 1'b0);

    // 5a: quota field 0 acts as 1
    start("t5a");
    set_q(2, 0); push(2, 3);
    run(6);
    for (int c = 0; c < 6; c++) p6[c] = gnt_log[c][2];
    chk("t5a_pat", p6, 6'b101010);

    // 5b: source 2 empties after 3 of 8; pointer moves to 3 so 4 beats 0
    start("t5b");
    set_q(2, 8); push(2, 3);
    run(5);
    push(0, 1); push(4, 1);
    run(6);
    chk("t5b_w3", qi(2), 2);
    chk("t5b_w3_cyc", (xcyc.size() > 2) ? xcyc[2] : -1, 3);
    chk("t5b_ptr", qi(3), 4);
    chk("t5b_wrap", qi(4), 0);

    // 6: reset mid-burst of source 7 with pointer parked at 9
    start("t6");
    set_q(7, 4); push(8, 1);
    run(3);
    push(7, 4);
    run(3);
    push(9, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_gnt", gnt_log[6], '0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_gid", gid, '0);
    run(7);
    chk("t6_first", qi(0), 8);
    chk("t6_after_rst", qi(3), 7);
    chk("t6_after_cyc", (xcyc.size() > 3) ? xcyc[3] : -1, 8);
    chk("t6_data", (xdat.size() > 3) ? xdat[3] : '1, word(7, 2));
    chk("t6_last", qi(5), 9);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
